// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: opcode constants and FSM state encoding shared by mem_dump_reg
package mem_dump_pkg;
  localparam logic [1:0] OP_NOP_CLR   = 2'b00;
  localparam logic [1:0] OP_DUMP      = 2'b01;
  localparam logic [1:0] OP_WRITE     = 2'b10;
  localparam logic [1:0] OP_WRITE_XOR = 2'b11;
  typedef enum logic [1:0] {IDLE, WRITE, DUMP, CLEAR} state_t;
endpackage

// File: rtl/mem_single.sv
// mem_single: single-port RAM with synchronous write and 1-cycle registered read (clk, we, addr, wdata -> rdata)
module mem_single #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_dump_reg.sv
// mem_dump_reg: opcode-driven write/masked-write/burst-dump/clear memory target (load_i, data_i, key_i -> data_o, valid_o, busy_o)
module mem_dump_reg
  import mem_dump_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] key_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              busy_o
);
  localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   cnt, n_req;
  logic [WORD_W-1:0] wdata, word, rdata, mem_wdata;
  logic [1:0]        op, v;
  logic              issue, we, unused_bits;
  assign op          = data_i[DATA_W-1 -: 2];
  assign n_req       = data_i[ADDR_W:0];
  assign word        = op == OP_WRITE_XOR ? data_i[WORD_W-1:0] ^ key_i[DATA_W-1 -: WORD_W] : data_i[WORD_W-1:0];
  assign issue       = state == DUMP && cnt != '0;
  assign we          = state == WRITE || (state == CLEAR && cnt != '0);
  assign mem_wdata   = state == CLEAR ? '0 : wdata;
  assign valid_o     = v[1];
  assign unused_bits = ^{data_i, key_i};
  mem_single #(.WIDTH(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk), .we(we), .addr(addr), .wdata(mem_wdata), .rdata(rdata)
  );
  // v tracks reads in flight: v[0] = read issued last edge, v[1] = word now on data_o
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      wdata  <= '0;
      v      <= '0;
      data_o <= '0;
      busy_o <= 1'b0;
    end else begin
      v <= {v[0], issue};
      if (v[0]) data_o <= DATA_W'(rdata);
      case (state)
        IDLE: if (load_i) begin
          if (op == OP_WRITE || op == OP_WRITE_XOR) begin
            state  <= WRITE;
            busy_o <= 1'b1;
            addr   <= key_i[ADDR_W-1:0];
            wdata  <= word;
            data_o <= DATA_W'(word);
          end else if (op == OP_DUMP) begin
            state  <= DUMP;
            busy_o <= 1'b1;
            addr   <= key_i[ADDR_W-1:0];
            cnt    <= (n_req == '0 || n_req > FULL) ? FULL : n_req;
            data_o <= '0;
          end else if (op == OP_NOP_CLR && data_i[0]) begin
            state  <= CLEAR;
            busy_o <= 1'b1;
            addr   <= '0;
            cnt    <= FULL;
            data_o <= '0;
          end
        end
        WRITE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        // DUMP and CLEAR walk cnt words; DUMP then drains until no read is in flight
        default: if (cnt != '0) begin
          cnt  <= cnt - 1'b1;
          addr <= addr == LAST ? '0 : addr + 1'b1;
        end else if (!v[0]) begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_dump_reg.md
# mem_dump_reg

Parametrised capture-and-dump memory target for the CW305 power-analysis fabric. It sits behind the same 128-bit load/data/key host interface as the existing register targets and decodes an opcode from the top of `data_i`. Supported commands are word writes (plain or key-masked), bounded burst dumps from any start address with wrap-around, and a full-memory clear. Dumped words are marked with `valid_o`, so the host no longer has to count cycles.

## Interface
Parameters:
- `DATA_W`, 128, host bus width; must be at least `WORD_W + 2`.
- `WORD_W`, 32, stored word width.
- `DEPTH`, 128, number of memory words; must be at least 2 (any value allowed, not only powers of two).
- `ADDR_W`, `clog2(DEPTH)`, address width (derived).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `load_i`  in  1  command strobe; sampled only in IDLE.
- `data_i`  in  `DATA_W`  command/payload.
- `key_i`  in  `DATA_W`  address, start address and XOR mask.
- `data_o`  out  `DATA_W`  echo or dump word, zero-extended.
- `valid_o`  out  1  `data_o` holds a dump word this cycle.
- `busy_o`  out  1  command in progress; `load_i` is ignored while high.

## Operation
- Opcode is `op = data_i[DATA_W-1:DATA_W-2]`. Write address and dump start address are both `key_i[ADDR_W-1:0]`.
- **op 2'b10, WRITE:** `mem[addr] <= data_i[WORD_W-1:0]`; `data_o` echoes the written word.
- **op 2'b11, WRITE_XOR:** `mem[addr] <= data_i[WORD_W-1:0] ^ key_i[DATA_W-1 -: WORD_W]`; `data_o` echoes the masked word.
- **op 2'b01, DUMP:**
  - Count `N = data_i[ADDR_W:0]`; a count of 0 or greater than `DEPTH` is treated as `N = DEPTH`.
  - Reads N words starting at the start address, incrementing.
  - The address wraps from `DEPTH-1` to 0 by explicit compare.
- **op 2'b00:** if `data_i[0]` is 1, CLEAR (writes 0 to all `DEPTH` entries, address 0 upward); otherwise NOP (no state change, `busy_o` stays low).
- **States:** IDLE, WRITE, DUMP, CLEAR.
  - IDLE goes to WRITE, DUMP or CLEAR on `load_i` with a matching opcode.
  - WRITE returns to IDLE after 1 cycle.
  - DUMP returns to IDLE after the last word is issued plus 2 cycles of pipeline drain.
  - CLEAR returns to IDLE after `DEPTH` write cycles.
- `load_i` asserted outside IDLE is dropped, not queued.
- **Reset:**
  - `data_o = 0`, `valid_o = 0`, `busy_o = 0`, state IDLE, address and counters 0.
  - Reset mid-DUMP or mid-CLEAR aborts immediately. Memory is not reset, so a partially cleared array remains partially cleared.

## Timing
E0 is the edge that samples `load_i`.
- **WRITE / WRITE_XOR:**
  - `busy_o = 1` and `data_o` = echo after E0.
  - The memory write commits at E0+1; `busy_o = 0` after E0+1.
  - A DUMP issued at E0+1 or later reads the new value.
- **DUMP:**
  - The memory has 1-cycle synchronous read and `data_o` is registered.
  - Word i (i = 0..N-1) is on `data_o` with `valid_o = 1` after edge E0+2+i.
  - `data_o = 0`, `valid_o = 0` and `busy_o = 1` after E0+1.
  - After E0+N+2: `valid_o = 0`, `busy_o = 0`, and `data_o` holds the last word.
- **CLEAR:**
  - `busy_o = 1` from E0.
  - Entry j is written at edge E0+1+j.
  - `busy_o = 0` after E0+DEPTH+1.
  - `data_o = 0` and `valid_o = 0` throughout.
- **Throughput:** back-to-back commands are accepted on the first edge with `busy_o = 0`.

## Structure
- **Shared package `mem_dump_pkg`:**
  - opcode constants `OP_NOP_CLR`, `OP_DUMP`, `OP_WRITE`, `OP_WRITE_XOR`;
  - state enum `{IDLE, WRITE, DUMP, CLEAR}`.
- **Sub-module:** the existing single-port `mem_single` (`WIDTH = WORD_W`, `DEPTH = DEPTH`), with 1-cycle registered read and synchronous write.
- The address/write-data/write-enable mux and the FSM stay in the top level.
- The read-valid pipeline is a 2-stage shift register, separate from the state register, so that aborting on reset cannot leave a stale `valid_o`.

## Test plan
- **Write then dump:**
  - WRITE 0xDEADBEEF at addr 5, WRITE 0x12345678 at addr 6.
  - Then DUMP start 5, N=2 -> `valid_o` high for exactly 2 cycles with 0xDEADBEEF, 0x12345678 at E0+2 and E0+3; `busy_o` low after E0+4.
- **Masked write:** WRITE_XOR data 0xFFFF0000, mask 0x0F0F0F0F at addr 0 -> dump of addr 0 returns 0xF0F00F0F.
- **Wrap-around:**
  - Fill all entries with mem[k]=k.
  - DUMP start `DEPTH-2`, N=4 -> words `DEPTH-2`, `DEPTH-1`, 0, 1.
  - Also repeat with `DEPTH = 100` to cover a non-power-of-two depth.
- **Full dump and clear:**
  - DUMP with N=0 -> `DEPTH` valid words.
  - CLEAR -> `busy_o` high for `DEPTH+1` cycles; a subsequent full dump returns all zeros.
- **Busy drop:** `load_i` with a WRITE at addr 3 during a DUMP -> ignored; mem[3] unchanged, and the dump count and sequence are unaffected.
- **Reset abort:**
  - Assert `rst` mid-DUMP, e.g. at E0+10 -> `data_o`, `valid_o` and `busy_o` are 0 immediately.
  - The next command after reset behaves normally.
